score_keeper: RTL and testbench
===============================

# score_keeper

Tracks the point tally of a two-player pong match and drives the 8-bit `PLAYER_ONE`/`PLAYER_TWO` score buses read by the on-screen score renderer. It sits between the ball/paddle physics stage, which reports goals as single-cycle miss pulses, and the score renderer. It owns match sequencing (idle, rally, post-point pause, game over) and latches displayed scores only at frame boundaries so a score never changes mid-frame.

## Interface
- `WIN_SCORE`, 9: points needed to win; legal range 1..9, because the renderer draws a single digit.
- `PAUSE_FRAMES`, 60: frame ticks to wait after a point before the next serve; legal range 1..255.
- `clk` in 1: system/pixel clock; all logic is on its rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `FRAME_TICK` in 1: one-cycle pulse, once per video frame at the start of vertical blanking.
- `START` in 1: one-cycle pulse that starts a new match.
- `P1_MISS` in 1: one-cycle pulse when the ball passes player one's goal line; awards a point to player two.
- `P2_MISS` in 1: one-cycle pulse when the ball passes player two's goal line; awards a point to player one.
- `PLAYER_ONE` out 8: displayed score for player one, value 0..WIN_SCORE.
- `PLAYER_TWO` out 8: displayed score for player two, value 0..WIN_SCORE.
- `SERVE` out 1: one-cycle pulse telling the physics stage to launch the ball.
- `SERVE_DIR` out 1: serve direction; 0 = toward player one, 1 = toward player two. Valid whenever `SERVE`=1.
- `GAME_OVER` out 1: high while in the OVER state.
- `WINNER` out 1: 0 = player one won, 1 = player two won. Meaningful only while `GAME_OVER`=1.

## Operation
- Internal counters `s1` and `s2` (4 bit) hold the live score. `PLAYER_ONE`/`PLAYER_TWO` are zero-extended shadow copies of them.
- States:
  - **IDLE**: waits for a match to start.
    - `START` → clear `s1`/`s2`, pulse `SERVE` with `SERVE_DIR`=0, go to PLAY.
  - **PLAY**: rally in progress.
    - `P1_MISS` alone → `s2`++, `SERVE_DIR`←0 (serve toward the player who lost the point). If the new `s2` equals WIN_SCORE, go to OVER with `WINNER`=1; otherwise go to POINT.
    - `P2_MISS` alone → symmetric: `s1`++, `SERVE_DIR`←1, `WINNER`=0 on a win.
    - Both misses in the same cycle → no score change, `SERVE_DIR` unchanged, go to POINT.
  - **POINT**: post-point pause.
    - The pause counter clears on entry and increments on each `FRAME_TICK`.
    - On the tick that brings the counter to PAUSE_FRAMES → go to PLAY with a `SERVE` pulse.
  - **OVER**: match finished; `GAME_OVER`=1.
    - `START` → same action as in IDLE.
- Event filtering:
  - Miss pulses outside PLAY are ignored.
  - `START` outside IDLE/OVER is ignored.
- Counters saturate at WIN_SCORE and never wrap.
- Display update: on every clock edge with `FRAME_TICK`=1, the shadow outputs load the pre-edge `s1`/`s2`.

## Timing
- Reset values:
  - State IDLE; `s1`, `s2` and the pause counter = 0.
  - `PLAYER_ONE` = `PLAYER_TWO` = 0.
  - `SERVE` = `SERVE_DIR` = `GAME_OVER` = `WINNER` = 0.
- All outputs are registered.
- Miss pulse at cycle t → `s1`/`s2` and the state are updated at edge t+1. The shadow output changes at the edge ending the first cycle t' > t with `FRAME_TICK`=1.
- Miss and `FRAME_TICK` in the same cycle → the shadow loads the old value; the new value appears one frame later.
- `SERVE` is high for exactly the one cycle following the edge that enters PLAY.
- Pause length is exactly PAUSE_FRAMES `FRAME_TICK` pulses, counted after POINT is entered. A tick coincident with the entering miss is not counted.
- `START` resets the counters immediately, but the displayed scores drop to 0 only at the next `FRAME_TICK`.
- Reset asserted mid-match → all state returns to reset values asynchronously. After `RESET_N` rises, the block sits in IDLE until `START`.

## Structure
- Shared package `pong_pkg` holds:
  - the state enum (IDLE, PLAY, POINT, OVER);
  - `SCORE_W`=8;
  - `MAX_DIGIT`=9.
- Sub-module `pause_timer`: 8-bit frame counter with synchronous clear, `FRAME_TICK` enable and a terminal-count `done` output. The FSM, score counters and shadow registers stay in `score_keeper`.

## Test plan
- Reset then idle: with no `START`, 10 `P1_MISS` pulses → scores stay 0/0, `SERVE` never asserts.
- Basic point: `START`, then `P2_MISS` → `PLAYER_ONE` stays 0 until the next `FRAME_TICK`, then reads 1. After 60 ticks, `SERVE`=1 for 1 cycle with `SERVE_DIR`=1.
- Simultaneous misses: `P1_MISS` and `P2_MISS` in the same cycle during PLAY → scores unchanged, POINT entered, `SERVE` after 60 ticks.
- Win, with WIN_SCORE=3: three `P1_MISS` rallies → `GAME_OVER`=1, `WINNER`=1, `PLAYER_TWO`=3 after the next tick. A further `P1_MISS` leaves the score at 3.
- Restart: `START` in OVER → `GAME_OVER`=0, `SERVE` pulse with `SERVE_DIR`=0, and both scores read 0 after the next `FRAME_TICK`.
- Reset mid-pause: drop `RESET_N` in POINT with score 2/1 → all outputs 0 immediately; no `SERVE` after release.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match-sequencing blocks.
package pong_pkg;

  localparam int SCORE_W   = 8;
  localparam int MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/pause_timer.sv
// Post-point frame counter: cleared while idle, counts frame ticks, flags the
// tick that reaches the programmed pause length.
module pause_timer #(
  parameter int FRAMES = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Fires on the tick that will bring the count up to FRAMES.
  assign done = enable && !clear && (count == 8'(FRAMES - 1));

endmodule

// File: rtl/score_keeper.sv
// Pong match sequencer: tracks the live score, paces serves and publishes
// frame-aligned score copies for the on-screen renderer.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic               FRAME_TICK,
  input  logic               START,
  input  logic               P1_MISS,
  input  logic               P2_MISS,
  output logic [SCORE_W-1:0] PLAYER_ONE,
  output logic [SCORE_W-1:0] PLAYER_TWO,
  output logic               SERVE,
  output logic               SERVE_DIR,
  output logic               GAME_OVER,
  output logic               WINNER
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t     state;
  logic [3:0] s1;
  logic [3:0] s2;
  logic       pause_done;

  // Counter is held clear outside POINT, so a tick coincident with the
  // entering miss is never counted.
  pause_timer #(
    .FRAMES (PAUSE_FRAMES)
  ) u_pause_timer (
    .clk    (clk),
    .rst_n  (RESET_N),
    .clear  (state != ST_POINT),
    .enable (FRAME_TICK),
    .done   (pause_done)
  );

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      s1         <= 4'd0;
      s2         <= 4'd0;
      PLAYER_ONE <= '0;
      PLAYER_TWO <= '0;
      SERVE      <= 1'b0;
      SERVE_DIR  <= 1'b0;
      GAME_OVER  <= 1'b0;
      WINNER     <= 1'b0;
    end else begin
      SERVE <= 1'b0;

      // Display copies take the pre-edge score, so a miss on a tick shows next frame.
      if (FRAME_TICK) begin
        PLAYER_ONE <= SCORE_W'(s1);
        PLAYER_TWO <= SCORE_W'(s2);
      end

      case (state)
        ST_IDLE, ST_OVER: begin
          if (START) begin
            s1        <= 4'd0;
            s2        <= 4'd0;
            SERVE     <= 1'b1;
            SERVE_DIR <= 1'b0;
            GAME_OVER <= 1'b0;
            state     <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (P1_MISS && P2_MISS) begin
            state <= ST_POINT;
          end else if (P1_MISS) begin
            s2        <= sat_inc(s2, WIN);
            SERVE_DIR <= 1'b0;
            if (sat_inc(s2, WIN) == WIN) begin
              state     <= ST_OVER;
              GAME_OVER <= 1'b1;
              WINNER    <= 1'b1;
            end else begin
              state <= ST_POINT;
            end
          end else if (P2_MISS) begin
            s1        <= sat_inc(s1, WIN);
            SERVE_DIR <= 1'b1;
            if (sat_inc(s1, WIN) == WIN) begin
              state     <= ST_OVER;
              GAME_OVER <= 1'b1;
              WINNER    <= 1'b0;
            end else begin
              state <= ST_POINT;
            end
          end
        end

        ST_POINT: begin
          if (pause_done) begin
            SERVE <= 1'b1;
            state <= ST_PLAY;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a table of single-cycle vectors followed by
// hand-written pause, win, restart and reset sequences.
module tb_score_keeper;

  logic       clk;
  logic       RESET_N;
  logic       FRAME_TICK;
  logic       START;
  logic       P1_MISS;
  logic       P2_MISS;
  logic [7:0] PLAYER_ONE;
  logic [7:0] PLAYER_TWO;
  logic       SERVE;
  logic       SERVE_DIR;
  logic       GAME_OVER;
  logic       WINNER;

  int vectors;
  int miscompares;

  score_keeper #(
    .WIN_SCORE    (3),
    .PAUSE_FRAMES (60)
  ) dut (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .FRAME_TICK (FRAME_TICK),
    .START      (START),
    .P1_MISS    (P1_MISS),
    .P2_MISS    (P2_MISS),
    .PLAYER_ONE (PLAYER_ONE),
    .PLAYER_TWO (PLAYER_TWO),
    .SERVE      (SERVE),
    .SERVE_DIR  (SERVE_DIR),
    .GAME_OVER  (GAME_OVER),
    .WINNER     (WINNER)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       p1;
    logic       p2;
    logic       tick;
    logic [7:0] e_one;
    logic [7:0] e_two;
    logic       e_serve;
    logic       e_dir;
    logic       e_over;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic st, input logic m1, input logic m2, input logic tk);
    START      = st;
    P1_MISS    = m1;
    P2_MISS    = m2;
    FRAME_TICK = tk;
    @(posedge clk);
    #1;
    START      = 1'b0;
    P1_MISS    = 1'b0;
    P2_MISS    = 1'b0;
    FRAME_TICK = 1'b0;
  endtask

  // Issue n ticks with a gap cycle after each; serve must appear only after the last.
  task automatic pause(input int n, input logic dir, input string tag);
    for (int i = 1; i <= n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (i < n) begin
        check($sformatf("%s serve early tick%0d", tag, i), {7'd0, SERVE}, 8'd0);
      end else begin
        check($sformatf("%s serve", tag), {7'd0, SERVE}, 8'd1);
        check($sformatf("%s serve_dir", tag), {7'd0, SERVE_DIR}, {7'd0, dir});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("%s serve width tick%0d", tag, i), {7'd0, SERVE}, 8'd0);
    end
  endtask

  task automatic check_display(input string tag, input logic [7:0] one, input logic [7:0] two);
    check({tag, " player_one"}, PLAYER_ONE, one);
    check({tag, " player_two"}, PLAYER_TWO, two);
  endtask

  initial begin
    int serve_seen;
    vectors     = 0;
    miscompares = 0;
    RESET_N     = 1'b0;
    START       = 1'b0;
    P1_MISS     = 1'b0;
    P2_MISS     = 1'b0;
    FRAME_TICK  = 1'b0;

    //            start p1  p2  tick  one  two  serve dir over
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_display("reset", 8'd0, 8'd0);
    check("reset serve", {7'd0, SERVE}, 8'd0);
    check("reset serve_dir", {7'd0, SERVE_DIR}, 8'd0);
    check("reset game_over", {7'd0, GAME_OVER}, 8'd0);
    check("reset winner", {7'd0, WINNER}, 8'd0);
    RESET_N = 1'b1;

    // Idle-mode misses are ignored: ten P1 misses, scores stay zero, no serve.
    serve_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (SERVE) serve_seen++;
    end
    check("idle serve count", 8'(serve_seen), 8'd0);
    check_display("idle misses", 8'd0, 8'd0);

    // Table: start, first point to player one, ignored events during the pause.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].start, tbl[i].p1, tbl[i].p2, tbl[i].tick);
      $display("vec %0d: st=%0b p1=%0b p2=%0b tk=%0b -> one=%0d two=%0d serve=%0b dir=%0b over=%0b",
               i, tbl[i].start, tbl[i].p1, tbl[i].p2, tbl[i].tick,
               PLAYER_ONE, PLAYER_TWO, SERVE, SERVE_DIR, GAME_OVER);
      check($sformatf("vec%0d player_one", i), PLAYER_ONE, tbl[i].e_one);
      check($sformatf("vec%0d player_two", i), PLAYER_TWO, tbl[i].e_two);
      check($sformatf("vec%0d serve", i), {7'd0, SERVE}, {7'd0, tbl[i].e_serve});
      check($sformatf("vec%0d serve_dir", i), {7'd0, SERVE_DIR}, {7'd0, tbl[i].e_dir});
      check($sformatf("vec%0d game_over", i), {7'd0, GAME_OVER}, {7'd0, tbl[i].e_over});
    end

    // Two ticks already counted in the table, 58 remain.
    pause(58, 1'b1, "pause1");
    check_display("after pause1", 8'd1, 8'd0);

    // Simultaneous misses: no score change, direction kept; coincident tick not counted.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_display("both miss", 8'd1, 8'd0);
    check("both miss serve", {7'd0, SERVE}, 8'd0);
    pause(60, 1'b1, "pause_both");
    check_display("after both", 8'd1, 8'd0);

    // Player two wins with three points.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pause(60, 1'b0, "win_r1");
    check_display("win r1", 8'd1, 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pause(60, 1'b0, "win_r2");
    check_display("win r2", 8'd1, 8'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("win game_over", {7'd0, GAME_OVER}, 8'd1);
    check("win winner", {7'd0, WINNER}, 8'd1);
    check("win serve", {7'd0, SERVE}, 8'd0);
    check_display("win before tick", 8'd1, 8'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_display("win after tick", 8'd1, 8'd3);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_display("over extra miss", 8'd1, 8'd3);
    check("over still game_over", {7'd0, GAME_OVER}, 8'd1);

    // Restart from OVER: counters clear now, display clears at the next tick.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart game_over", {7'd0, GAME_OVER}, 8'd0);
    check("restart serve", {7'd0, SERVE}, 8'd1);
    check("restart serve_dir", {7'd0, SERVE_DIR}, 8'd0);
    check_display("restart before tick", 8'd1, 8'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("restart serve width", {7'd0, SERVE}, 8'd0);
    check_display("restart after tick", 8'd0, 8'd0);

    // Build 2/1 and reset in the middle of the pause.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    pause(60, 1'b1, "rst_r1");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    pause(60, 1'b1, "rst_r2");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_display("pre reset", 8'd2, 8'd1);
    check("pre reset serve_dir", {7'd0, SERVE_DIR}, 8'd0);
    #2;
    RESET_N = 1'b0;
    #1;
    check_display("async reset", 8'd0, 8'd0);
    check("async reset serve", {7'd0, SERVE}, 8'd0);
    check("async reset serve_dir", {7'd0, SERVE_DIR}, 8'd0);
    check("async reset game_over", {7'd0, GAME_OVER}, 8'd0);
    check("async reset winner", {7'd0, WINNER}, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    RESET_N = 1'b1;

    serve_seen = 0;
    for (int i = 0; i < 150; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (SERVE) serve_seen++;
    end
    check("post reset serve count", 8'(serve_seen), 8'd0);
    check_display("post reset", 8'd0, 8'd0);
    check("post reset game_over", {7'd0, GAME_OVER}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
